// File: rtl/st_capture_reg.sv
`default_nettype none
// ============================================================================
// Module   : st_capture_reg
// Purpose  : Status capture stage for a read-only register slice. Raw status
//            bits from inner logic are glitch-filtered. Each filtered bit is
//            then presented either as a live level or as a sticky rising-edge
//            flag. Sticky flags clear on a permitted read of this register's
//            address. A maskable interrupt is raised from the sticky flags.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   i_clk       in   1   clock
//   i_rst_n     in   1   asynchronous active-low reset
//   i_st_raw    in   DW  raw status, synchronous to i_clk
//   i_ren       in   1   register read strobe
//   i_addr      in   AW  register address
//   i_rd_en     in   1   read permission (OR of mode enables, upstream)
//   i_irq_mask  in   DW  per-bit interrupt enable, 1 = enabled
//   o_ff_data   out  DW  status word to the read-only register
//   o_irq       out  1   registered interrupt
//   o_evt_cnt   out  CW  saturating rise count of filtered bit EVT_BIT
// ----------------------------------------------------------------------------
// Build option
//   ST_CAPTURE_EVT_CNT_EN : when defined, the event counter is built.
//                           When undefined, o_evt_cnt is tied to 0.
// ============================================================================
module st_capture_reg #(
    parameter int              DW          = 8,
    parameter int              AW          = 8,
    parameter logic [AW-1:0]   REG_ADDR    = {AW{1'b0}},
    parameter logic [DW-1:0]   STICKY_MASK = {DW{1'b1}},
    parameter int              FILT_CYC    = 2,
    parameter int              EVT_BIT     = 0,
    parameter int              CW          = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [DW-1:0]     i_st_raw,
    input  logic              i_ren,
    input  logic [AW-1:0]     i_addr,
    input  logic              i_rd_en,
    input  logic [DW-1:0]     i_irq_mask,
    output logic [DW-1:0]     o_ff_data,
    output logic              o_irq,
    output logic [CW-1:0]     o_evt_cnt
);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter legality
    // ------------------------------------------------------------------------
    if ((EVT_BIT < 0) || (EVT_BIT >= DW) || (FILT_CYC < 1) || (FILT_CYC > 255)) begin : g_param_err
        $error("st_capture_reg: EVT_BIT must be < DW and FILT_CYC in 1..255");
    end

    // Counter value at which a pending change is accepted.
    localparam logic [7:0] c_FILT_LAST = 8'(FILT_CYC - 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [DW-1:0] r_filt;
    logic [7:0]    r_cnt [DW];
    logic [DW-1:0] r_sticky;
    logic          r_irq;

    logic [DW-1:0] w_filt_next;
    logic [7:0]    w_cnt_next [DW];
    logic [DW-1:0] w_rise;
    logic          w_rd_clr;

    // ------------------------------------------------------------------------
    // Glitch filter: a bit must differ from its filtered value on FILT_CYC
    // consecutive edges before the new value is accepted. Any edge where raw
    // matches the filtered value restarts the count.
    // ------------------------------------------------------------------------
    always_comb begin
        w_filt_next = r_filt;
        for (int i = 0; i < DW; i++) begin
            w_cnt_next[i] = 8'd0;
            if (i_st_raw[i] != r_filt[i]) begin
                if (r_cnt[i] == c_FILT_LAST) begin
                    w_filt_next[i] = i_st_raw[i];
                end else begin
                    w_cnt_next[i] = r_cnt[i] + 8'd1;
                end
            end
        end
    end

    // Rise is taken on the same edge that updates the filtered value.
    assign w_rise   = w_filt_next & ~r_filt;

    // Combinational so it acts on the edge that ends the read cycle. The read
    // mux downstream therefore still sees the pre-clear value.
    assign w_rd_clr = i_ren & (i_addr == REG_ADDR) & i_rd_en;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_filt   <= '0;
            r_sticky <= '0;
            r_irq    <= 1'b0;
            for (int i = 0; i < DW; i++) begin
                r_cnt[i] <= 8'd0;
            end
        end else begin
            r_filt   <= w_filt_next;
            // Set wins over clear when both happen on the same edge.
            r_sticky <= (r_sticky & ~{DW{w_rd_clr}}) | w_rise;
            // Live bits are excluded so they never raise the interrupt.
            r_irq    <= |(r_sticky & i_irq_mask & STICKY_MASK);
            for (int i = 0; i < DW; i++) begin
                r_cnt[i] <= w_cnt_next[i];
            end
        end
    end

    assign o_ff_data = (STICKY_MASK & r_sticky) | (~STICKY_MASK & r_filt);
    assign o_irq     = r_irq;

    // ------------------------------------------------------------------------
    // Optional saturating event counter on filtered bit EVT_BIT
    // ------------------------------------------------------------------------
`ifdef ST_CAPTURE_EVT_CNT_EN
    localparam logic [CW-1:0] c_EVT_MAX = {CW{1'b1}};
    localparam logic [CW-1:0] c_EVT_ONE = CW'(1);

    logic [CW-1:0] r_evt_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_evt_cnt <= '0;
        end else if (w_rd_clr) begin
            // A rise coinciding with the clear counts as the first new event.
            r_evt_cnt <= w_rise[EVT_BIT] ? c_EVT_ONE : '0;
        end else if (w_rise[EVT_BIT] && (r_evt_cnt != c_EVT_MAX)) begin
            r_evt_cnt <= r_evt_cnt + c_EVT_ONE;
        end
    end

    assign o_evt_cnt = r_evt_cnt;
`else
    assign o_evt_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_st_capture_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_st_capture_reg
// Purpose  : Self-checking bench for st_capture_reg. Two instances share the
//            stimulus: dut0 (all sticky, FILT_CYC=2, 8-bit counter on bit 0)
//            and dut1 (STICKY_MASK=8'h0F, FILT_CYC=3, 2-bit counter on bit 3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_st_capture_reg;

    localparam logic [7:0] RA = 8'h24;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] st_raw;
    logic       ren;
    logic [7:0] addr;
    logic       rd_en;
    logic [7:0] irq_mask;
    logic [7:0] ff_data0, ff_data1;
    logic       irq0, irq1;
    logic [7:0] evt_cnt0;
    logic [1:0] evt_cnt1;

    always #5 clk = ~clk;

    st_capture_reg #(
        .DW(8), .AW(8), .REG_ADDR(RA), .STICKY_MASK(8'hFF),
        .FILT_CYC(2), .EVT_BIT(0), .CW(8)
    ) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_st_raw(st_raw), .i_ren(ren),
        .i_addr(addr), .i_rd_en(rd_en), .i_irq_mask(irq_mask),
        .o_ff_data(ff_data0), .o_irq(irq0), .o_evt_cnt(evt_cnt0)
    );

    st_capture_reg #(
        .DW(8), .AW(8), .REG_ADDR(RA), .STICKY_MASK(8'h0F),
        .FILT_CYC(3), .EVT_BIT(3), .CW(2)
    ) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_st_raw(st_raw), .i_ren(ren),
        .i_addr(addr), .i_rd_en(rd_en), .i_irq_mask(irq_mask),
        .o_ff_data(ff_data1), .o_irq(irq1), .o_evt_cnt(evt_cnt1)
    );

    // ------------------------------------------------------------------------
    // Reference model. The filter is expressed as "the last FILT_CYC samples
    // all disagree with the filtered value", using a sample history.
    // ------------------------------------------------------------------------
    int         fc   [2] = '{2, 3};
    logic [7:0] sm   [2] = '{8'hFF, 8'h0F};
    int         eb   [2] = '{0, 3};
    int         cmax [2] = '{255, 3};

    logic [7:0] m_hist   [2][3];
    logic [7:0] m_filt   [2];
    logic [7:0] m_sticky [2];
    logic       m_irq    [2];
    int         m_cnt    [2];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 3; j++) m_hist[k][j] = 8'h00;
            m_filt[k]   = 8'h00;
            m_sticky[k] = 8'h00;
            m_irq[k]    = 1'b0;
            m_cnt[k]    = 0;
        end
    endtask

    task automatic model_step();
        logic       rdclr;
        logic [7:0] newf;
        logic [7:0] rise;
        logic       all_diff;
        rdclr = ren && (addr == RA) && rd_en;
        for (int k = 0; k < 2; k++) begin
            for (int j = 2; j > 0; j--) m_hist[k][j] = m_hist[k][j-1];
            m_hist[k][0] = st_raw;
            newf = m_filt[k];
            for (int b = 0; b < 8; b++) begin
                all_diff = 1'b1;
                for (int j = 0; j < fc[k]; j++)
                    if (m_hist[k][j][b] == m_filt[k][b]) all_diff = 1'b0;
                if (all_diff) newf[b] = ~m_filt[k][b];
            end
            rise        = newf & ~m_filt[k];
            m_irq[k]    = |(m_sticky[k] & irq_mask & sm[k]);
            m_sticky[k] = (rdclr ? 8'h00 : m_sticky[k]) | rise;
            if (rdclr)
                m_cnt[k] = rise[eb[k]] ? 1 : 0;
            else if (rise[eb[k]] && (m_cnt[k] < cmax[k]))
                m_cnt[k] = m_cnt[k] + 1;
            m_filt[k] = newf;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step();
    end

    function automatic logic [7:0] exp_data(int k);
        return (sm[k] & m_sticky[k]) | (~sm[k] & m_filt[k]);
    endfunction

    function automatic int exp_evt(int k);
`ifdef ST_CAPTURE_EVT_CNT_EN
        return m_cnt[k];
`else
        return 0 * k;
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("model_data0", {24'd0, ff_data0}, {24'd0, exp_data(0)});
        chk("model_irq0",  {31'd0, irq0},     {31'd0, m_irq[0]});
        chk("model_evt0",  {24'd0, evt_cnt0}, exp_evt(0));
        chk("model_data1", {24'd0, ff_data1}, {24'd0, exp_data(1)});
        chk("model_irq1",  {31'd0, irq1},     {31'd0, m_irq[1]});
        chk("model_evt1",  {30'd0, evt_cnt1}, exp_evt(1));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        check_model();
    endtask

    // ------------------------------------------------------------------------
    // Directed vectors for dut0: inputs held for one cycle, expected outputs
    // observed just after the edge that samples them.
    // ------------------------------------------------------------------------
    typedef struct {
        logic [7:0] raw;
        logic       ren;
        logic [7:0] addr;
        logic       rd_en;
        logic [7:0] mask;
        logic [7:0] exp_data;
        logic       exp_irq;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [7:0] raw, input logic r, input logic [7:0] a,
                       input logic re, input logic [7:0] m,
                       input logic [7:0] ed, input logic ei);
        vec_t v;
        v.raw = raw; v.ren = r; v.addr = a; v.rd_en = re; v.mask = m;
        v.exp_data = ed; v.exp_irq = ei;
        tbl.push_back(v);
    endtask

    int evt_exp [5];
    int evt_coin;

    initial begin
        // raw FF held through reset
        add(8'hFF, 0, RA,    0, 8'hFF, 8'h00, 0);
        add(8'hFF, 0, RA,    0, 8'hFF, 8'hFF, 0);
        add(8'hFF, 0, RA,    0, 8'hFF, 8'hFF, 1);
        // clear everything
        add(8'h00, 1, RA,    1, 8'hFF, 8'h00, 1);
        add(8'h00, 0, RA,    0, 8'hFF, 8'h00, 0);
        add(8'h00, 0, RA,    0, 8'hFF, 8'h00, 0);
        // one-cycle glitch on bit 3
        add(8'h08, 0, RA,    0, 8'hFF, 8'h00, 0);
        add(8'h00, 0, RA,    0, 8'hFF, 8'h00, 0);
        add(8'h00, 0, RA,    0, 8'hFF, 8'h00, 0);
        // two-cycle pulse on bit 3
        add(8'h08, 0, RA,    0, 8'hFF, 8'h00, 0);
        add(8'h08, 0, RA,    0, 8'hFF, 8'h08, 0);
        add(8'h00, 0, RA,    0, 8'hFF, 8'h08, 1);
        add(8'h00, 0, RA,    0, 8'hFF, 8'h08, 1);
        add(8'h00, 0, RA,    0, 8'hFF, 8'h08, 1);
        // denied read, wrong address, then valid read
        add(8'h00, 1, RA,    0, 8'hFF, 8'h08, 1);
        add(8'h00, 1, 8'h25, 1, 8'hFF, 8'h08, 1);
        add(8'h00, 1, RA,    1, 8'hFF, 8'h00, 1);
        add(8'h00, 0, RA,    0, 8'hFF, 8'h00, 0);
        // bit 1 sticky, then bit 5 rises on the clearing edge
        add(8'h02, 0, RA,    0, 8'hFF, 8'h00, 0);
        add(8'h02, 0, RA,    0, 8'hFF, 8'h02, 0);
        add(8'h22, 0, RA,    0, 8'hFF, 8'h02, 1);
        add(8'h22, 1, RA,    1, 8'hFF, 8'h20, 1);
        add(8'h22, 0, RA,    0, 8'hFF, 8'h20, 1);
        // interrupt masking
        add(8'h22, 0, RA,    0, 8'h00, 8'h20, 0);
        add(8'h22, 0, RA,    0, 8'h20, 8'h20, 1);

`ifdef ST_CAPTURE_EVT_CNT_EN
        evt_exp  = '{1, 2, 3, 3, 3};
        evt_coin = 1;
`else
        evt_exp  = '{0, 0, 0, 0, 0};
        evt_coin = 0;
`endif

        // ---------------- reset with raw held high ----------------
        rst_n = 1'b0; st_raw = 8'hFF; ren = 1'b0; addr = 8'h00;
        rd_en = 1'b0; irq_mask = 8'hFF;
        repeat (3) begin
            @(posedge clk); #1;
            chk("rst_data0", {24'd0, ff_data0}, 32'h0);
            chk("rst_irq0",  {31'd0, irq0},     32'h0);
            chk("rst_evt0",  {24'd0, evt_cnt0}, 32'h0);
            chk("rst_data1", {24'd0, ff_data1}, 32'h0);
        end
        rst_n = 1'b1;

        // ---------------- table-driven vectors ----------------
        foreach (tbl[r]) begin
            st_raw = tbl[r].raw; ren = tbl[r].ren; addr = tbl[r].addr;
            rd_en = tbl[r].rd_en; irq_mask = tbl[r].mask;
            @(posedge clk); #1;
            chk($sformatf("tbl%0d_data", r), {24'd0, ff_data0}, {24'd0, tbl[r].exp_data});
            chk($sformatf("tbl%0d_irq", r),  {31'd0, irq0},     {31'd0, tbl[r].exp_irq});
            check_model();
        end

        // ---------------- event counter saturation (dut1, CW=2) ----------------
        ren = 1'b0; rd_en = 1'b1; addr = RA; irq_mask = 8'hFF; st_raw = 8'h00;
        repeat (4) tick();
        ren = 1'b1; tick(); ren = 1'b0;
        for (int k = 0; k < 5; k++) begin
            st_raw = 8'h08; repeat (3) tick();
            chk($sformatf("evt_sat%0d", k), {30'd0, evt_cnt1}, evt_exp[k]);
            st_raw = 8'h00; repeat (3) tick();
        end
        st_raw = 8'h08; repeat (2) tick();
        ren = 1'b1; tick(); ren = 1'b0;
        chk("evt_coincident", {30'd0, evt_cnt1}, evt_coin);
        st_raw = 8'h00; repeat (4) tick();

        // ---------------- live bit 6 on dut1 ----------------
        ren = 1'b1; tick(); ren = 1'b0;
        repeat (2) tick();
        st_raw = 8'h40; repeat (4) tick();
        chk("live6_hi",     {31'd0, ff_data1[6]}, 32'h1);
        chk("live6_hi_irq", {31'd0, irq1},        32'h0);
        st_raw = 8'h00; repeat (4) tick();
        chk("live6_lo",     {31'd0, ff_data1[6]}, 32'h0);
        chk("live6_lo_irq", {31'd0, irq1},        32'h0);

        // ---------------- randomized against the model ----------------
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 149) == 0) begin
                rst_n = 1'b0;
                #1;
                check_model();
                tick();
                rst_n = 1'b1;
            end
            st_raw   = st_raw ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            ren      = ($urandom_range(0, 3) == 0);
            addr     = ($urandom_range(0, 1) == 1) ? RA : 8'($urandom);
            rd_en    = ($urandom_range(0, 3) != 0);
            irq_mask = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'hFF;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
